// File: rtl/cnt_sync_pkg.sv
// Shared types and Gray-code helpers for the Gray-counter receive path.
package cnt_sync_pkg;

    // Widest counter the helpers support; narrower values are zero-extended.
    localparam int unsigned MaxW = 32;

    typedef enum logic [1:0] {
        StAlign,
        StRun,
        StErr
    } state_e;

    // Binary bit i is the XOR of all Gray bits at or above i, within w bits.
    function automatic logic [MaxW-1:0] gray2bin(input logic [MaxW-1:0] g,
                                                 input int unsigned     w);
        logic [MaxW-1:0] b;
        b = '0;
        for (int i = 0; i < int'(MaxW); i++) begin
            if (i < int'(w)) begin
                b[i] = ^(g >> i);
            end
        end
        return b;
    endfunction

    function automatic logic [MaxW-1:0] bin2gray(input logic [MaxW-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/cdc_sync_bus.sv
// Plain multi-flop synchronizer for a Gray-coded bus; no logic between stages.
module cdc_sync_bus #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync_q [STAGES];
    logic [WIDTH-1:0] sync_d [STAGES];

    always_comb begin
        sync_d[0] = d;
        for (int i = 1; i < int'(STAGES); i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(STAGES); i++) begin
                sync_q[i] <= sync_d[i];
            end
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/cnt_sync_rx.sv
// Receives a remote Gray-coded event counter and replays each increment as a
// valid/ready event in the local clock domain.
module cnt_sync_rx
    import cnt_sync_pkg::*;
#(
    parameter int unsigned W           = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MAX_PEND    = 127
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] cnt_gray_in,
    input  logic         resync,
    output logic         evt_valid,
    input  logic         evt_ready,
    output logic [W-1:0] local_cnt,
    output logic [W-1:0] pending,
    output logic         aligned,
    output logic         err
);

    localparam int unsigned FillW = $clog2(SYNC_STAGES + 2);
    // Last fill count: synchronizer plus decode register are full.
    localparam logic [FillW-1:0] FillLast = FillW'(SYNC_STAGES + 1);
    localparam logic [W-1:0] PendMax = W'(MAX_PEND);

    logic [W-1:0]     sync_gray;
    logic [W-1:0]     remote_bin_d, remote_bin_q;
    logic [W-1:0]     local_cnt_d, local_cnt_q;
    logic [FillW-1:0] fill_d, fill_q;
    logic             err_d, err_q;
    state_e           state_d, state_q;

    cdc_sync_bus #(
        .WIDTH  (W),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (cnt_gray_in),
        .q     (sync_gray)
    );

    always_comb begin
        remote_bin_d = W'(gray2bin(MaxW'(sync_gray), W));
    end

    assign pending   = remote_bin_q - local_cnt_q;
    assign evt_valid = (state_q == StRun) && (pending != '0);
    assign aligned   = (state_q == StRun);
    assign local_cnt = local_cnt_q;
    assign err       = err_q;

    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        local_cnt_d = local_cnt_q;
        err_d       = err_q;
        if (resync) begin
            // Beats any same-cycle handshake; the local copy is reloaded anyway.
            err_d   = 1'b0;
            fill_d  = '0;
            state_d = StAlign;
        end else begin
            unique case (state_q)
                StAlign: begin
                    if (fill_q == FillLast) begin
                        local_cnt_d = remote_bin_q;
                        state_d     = StRun;
                    end else begin
                        fill_d = fill_q + FillW'(1);
                    end
                end
                StRun: begin
                    if (evt_valid && evt_ready) begin
                        local_cnt_d = local_cnt_q + W'(1);
                    end
                    if (pending > PendMax) begin
                        err_d   = 1'b1;
                        state_d = StErr;
                    end
                end
                StErr: begin
                end
                default: state_d = StAlign;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StAlign;
            fill_q       <= '0;
            remote_bin_q <= '0;
            local_cnt_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            fill_q       <= fill_d;
            remote_bin_q <= remote_bin_d;
            local_cnt_q  <= local_cnt_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: doc/cnt_sync_rx.md
# cnt_sync_rx

Receiving end of a Gray-coded event counter crossing into the `clk` domain. The block synchronizes the remote counter, decodes it to binary, and tracks a local copy. It re-emits one valid/ready event for each remote increment, so downstream logic in `clk` sees every `en` pulse of the remote 8-bit counter. It sits at the domain boundary of the CDC design, directly after the remote Gray-coded counter output.

## Interface
- W, 8: counter width; must match the remote counter.
- SYNC_STAGES, 2: synchronizer flop stages on `cnt_gray_in`; legal values are 2 or more.
- MAX_PEND, 127: largest legal backlog of unconsumed increments. Must be less than 2^(W-1).

- clk  in  1  local clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cnt_gray_in  in  W  remote counter, Gray-coded. It is asynchronous to `clk` and changes at most one bit per remote edge.
- resync  in  1  single-cycle request to re-align the local copy to the remote count; also clears `err`.
- evt_valid  out  1  one remote increment is pending.
- evt_ready  in  1  downstream accepts the event.
- local_cnt  out  W  binary count of accepted events, modulo 2^W.
- pending  out  W  backlog, equal to (remote_bin_q − local_cnt) mod 2^W.
- aligned  out  1  block is in RUN.
- err  out  1  sticky flag: backlog exceeded MAX_PEND.

## Operation
- Data path: `cnt_gray_in` passes through SYNC_STAGES flops, then a Gray-to-binary decode, then the `remote_bin_q` register.
- `pending` is combinational from `remote_bin_q` and `local_cnt`, using modulo-2^W subtraction, so wrap from 255 to 0 is handled naturally.
- State machine with three states:
  - ALIGN (entered on reset): wait SYNC_STAGES+1 cycles for the pipeline to fill, using a fill counter. Then load `local_cnt` ← `remote_bin_q` and go to RUN. No events are emitted.
  - RUN: `evt_valid` = (`pending` != 0). On `evt_valid && evt_ready`, `local_cnt` increments by 1 modulo 2^W. If `pending` > MAX_PEND, set `err` and go to ERR.
  - ERR: `evt_valid` = 0; `local_cnt` and `err` hold.
  - `resync` in any state: clear `err`, clear the fill counter, and go to ALIGN. `resync` has priority over a same-cycle handshake, so that handshake does not increment.
- Valid/ready rules:
  - Once asserted, `evt_valid` stays high until it is accepted. This holds because the remote count only advances.
  - Back-to-back acceptance is allowed at one event per cycle.
  - `evt_ready` while `evt_valid` is low has no effect.
- A remote increment arriving in the same cycle as a handshake changes `pending` by net 0; both updates apply.
- `aligned` = (state == RUN).
- The block never decrements `local_cnt` and never skips an event except through `resync`.

## Timing
- Reset values: `evt_valid`=0, `local_cnt`=0, `pending`=0, `aligned`=0, `err`=0, state=ALIGN. All synchronizer and `remote_bin_q` flops reset to 0.
- Latency: a `cnt_gray_in` change to `evt_valid` high takes SYNC_STAGES+1 `clk` edges (3 with defaults).
- After a handshake at edge N, `local_cnt` and `pending` update at edge N. `evt_valid` reflects the new `pending` in the same cycle.
- After reset release, `aligned` rises SYNC_STAGES+2 cycles later (4 with defaults).
- `err` rises in the cycle after `pending` first exceeds MAX_PEND.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous); any pending events are discarded.
- Throughput: 1 event per cycle maximum.

## Structure
- Package `cnt_sync_pkg` holds:
  - the state enum (ALIGN, RUN, ERR);
  - a `gray2bin` function parameterized on W;
  - a `bin2gray` function for the bench.
- Sub-module `cdc_sync_bus` (WIDTH, STAGES): a plain multi-flop synchronizer with asynchronous active-low reset. It has no logic between stages and is marked for CDC tool recognition.
- Top module contains the decode register, `local_cnt`, the FSM, and the fill counter.

## Test plan
- Reset, then hold `cnt_gray_in` = bin2gray(5) → `aligned` rises at cycle 4, `local_cnt`=5, `pending`=0, no `evt_valid`.
- In RUN with count 5, step the remote to 6, 7, 8 with `evt_ready`=1 → exactly 3 handshakes; `local_cnt` ends at 8; the first `evt_valid` appears 3 cycles after the first change.
- Remote steps 253 → 2 (wrap) with `evt_ready`=0 → `pending`=5, `evt_valid` held high. Then raise `evt_ready` → 5 back-to-back events; `local_cnt` ends at 2.
- With `evt_ready`=0, advance the remote by 128 → `err`=1, `evt_valid`=0, state ERR. Pulse `resync` → `err`=0, re-align to the remote value, no events emitted.
- Assert `rst_n` low while `pending`=3 → all outputs go to 0 at once. After release, ALIGN loads the current remote value with no replayed events.
- Remote increment and handshake in the same cycle while `pending`=1 → `pending` stays 1 and `local_cnt` increments by 1.
